// File: rtl/multicycle_control.sv
// Multicycle RV32I main controller: Moore FSM that sequences the shared datapath.
// Define MULTICYCLE_ILLEGAL_TRAP_EN to trap unknown opcodes instead of retiring them as NOPs.
module multicycle_control #(
  parameter int INSTRET_W = 32
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [6:0]           opcode,
  input  logic                 branch_taken,
  input  logic                 mem_ready,
  output logic                 mem_read,
  output logic                 mem_write,
  output logic                 adr_src,
  output logic                 ir_write,
  output logic                 pc_write,
  output logic                 reg_write,
  output logic [1:0]           alu_src_a,
  output logic [1:0]           alu_src_b,
  output logic [1:0]           alu_op,
  output logic [1:0]           result_src,
  output logic                 illegal_instr,
  output logic [INSTRET_W-1:0] instret,
  output logic [3:0]           dbg_state
);

  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_RTYPE  = 7'b0110011;
  localparam logic [6:0] OP_ITYPE  = 7'b0010011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;

  typedef enum logic [3:0] {
    S_FETCH    = 4'd0,
    S_DECODE   = 4'd1,
    S_MEMADR   = 4'd2,
    S_MEMREAD  = 4'd3,
    S_MEMWB    = 4'd4,
    S_MEMWRITE = 4'd5,
    S_EXECR    = 4'd6,
    S_EXECI    = 4'd7,
    S_LUI      = 4'd8,
    S_ALUWB    = 4'd9,
    S_BRANCH   = 4'd10,
    S_JALR     = 4'd11,
`ifdef MULTICYCLE_ILLEGAL_TRAP_EN
    S_JAL      = 4'd12,
    S_TRAP     = 4'd13
`else
    S_JAL      = 4'd12
`endif
  } state_t;

  state_t                 state_q, state_d;
  logic [INSTRET_W-1:0]   instret_q, instret_d;

  // Internal enables before reset gating.
  logic pc_update;
  logic branch;
  logic mem_read_raw;
  logic mem_write_raw;
  logic ir_write_raw;
  logic reg_write_raw;

  // Next-state logic.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      S_FETCH:    state_d = mem_ready ? S_DECODE : S_FETCH;
      S_DECODE: begin
        case (opcode)
          OP_LOAD, OP_STORE: state_d = S_MEMADR;
          OP_RTYPE:          state_d = S_EXECR;
          OP_ITYPE:          state_d = S_EXECI;
          OP_BRANCH:         state_d = S_BRANCH;
          OP_JAL:            state_d = S_JAL;
          OP_JALR:           state_d = S_JALR;
          OP_LUI:            state_d = S_LUI;
          OP_AUIPC:          state_d = S_ALUWB;
`ifdef MULTICYCLE_ILLEGAL_TRAP_EN
          default:           state_d = S_TRAP;
`else
          default:           state_d = S_FETCH;
`endif
        endcase
      end
      // opcode bit 5 separates store (0100011) from load (0000011).
      S_MEMADR:   state_d = opcode[5] ? S_MEMWRITE : S_MEMREAD;
      S_MEMREAD:  state_d = mem_ready ? S_MEMWB : S_MEMREAD;
      S_MEMWB:    state_d = S_FETCH;
      S_MEMWRITE: state_d = mem_ready ? S_FETCH : S_MEMWRITE;
      S_EXECR:    state_d = S_ALUWB;
      S_EXECI:    state_d = S_ALUWB;
      S_LUI:      state_d = S_ALUWB;
      S_ALUWB:    state_d = S_FETCH;
      S_BRANCH:   state_d = S_FETCH;
      S_JALR:     state_d = S_JAL;
      S_JAL:      state_d = S_ALUWB;
`ifdef MULTICYCLE_ILLEGAL_TRAP_EN
      S_TRAP:     state_d = S_TRAP;
`endif
      default:    state_d = S_FETCH;
    endcase
  end

  // An instruction retires on every return to FETCH; TRAP never returns.
  always_comb begin
    instret_d = instret_q;
    if ((state_q != S_FETCH) && (state_d == S_FETCH)) begin
      instret_d = instret_q + INSTRET_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= S_FETCH;
      instret_q <= '0;
    end else begin
      state_q   <= state_d;
      instret_q <= instret_d;
    end
  end

  // Memory handshake: mem_read/mem_write and adr_src are held stable while
  // mem_ready=0; the access completes in the first cycle with mem_ready=1.
  always_comb begin
    mem_read_raw  = 1'b0;
    mem_write_raw = 1'b0;
    ir_write_raw  = 1'b0;
    reg_write_raw = 1'b0;
    pc_update     = 1'b0;
    branch        = 1'b0;
    adr_src       = 1'b0;
    alu_src_a     = 2'b00;
    alu_src_b     = 2'b00;
    alu_op        = 2'b00;
    result_src    = 2'b00;
    unique case (state_q)
      S_FETCH: begin
        mem_read_raw = 1'b1;
        alu_src_b    = 2'b10;
        result_src   = 2'b10;
        ir_write_raw = mem_ready;
        pc_update    = mem_ready;
      end
      S_DECODE: begin
        alu_src_a = 2'b01;
        alu_src_b = 2'b01;
      end
      S_MEMADR: begin
        alu_src_a = 2'b10;
        alu_src_b = 2'b01;
      end
      S_MEMREAD: begin
        adr_src      = 1'b1;
        mem_read_raw = 1'b1;
      end
      S_MEMWB: begin
        result_src    = 2'b01;
        reg_write_raw = 1'b1;
      end
      S_MEMWRITE: begin
        adr_src       = 1'b1;
        mem_write_raw = 1'b1;
      end
      S_EXECR: begin
        alu_src_a = 2'b10;
        alu_op    = 2'b10;
      end
      S_EXECI: begin
        alu_src_a = 2'b10;
        alu_src_b = 2'b01;
        alu_op    = 2'b11;
      end
      S_LUI: begin
        alu_src_a = 2'b11;
        alu_src_b = 2'b01;
      end
      S_ALUWB: begin
        reg_write_raw = 1'b1;
      end
      S_BRANCH: begin
        alu_src_a = 2'b10;
        alu_op    = 2'b01;
        branch    = 1'b1;
      end
      S_JALR: begin
        alu_src_a = 2'b10;
        alu_src_b = 2'b01;
      end
      S_JAL: begin
        alu_src_a = 2'b01;
        alu_src_b = 2'b10;
        pc_update = 1'b1;
      end
      default: begin
      end
    endcase
  end

  // Reset suppresses every enable, so an access in flight is simply dropped.
  assign mem_read  = mem_read_raw & ~reset;
  assign mem_write = mem_write_raw & ~reset;
  assign ir_write  = ir_write_raw & ~reset;
  assign reg_write = reg_write_raw & ~reset;
  assign pc_write  = (pc_update | (branch & branch_taken)) & ~reset;

`ifdef MULTICYCLE_ILLEGAL_TRAP_EN
  assign illegal_instr = (state_q == S_TRAP);
`else
  assign illegal_instr = 1'b0;
`endif

  assign instret   = instret_q;
  assign dbg_state = state_q;

endmodule

// File: tb/tb_multicycle_control.sv
// Directed bench for multicycle_control: a driver pushes the hand-computed
// control word and instret for each cycle; a negedge monitor pops and compares.
module tb_multicycle_control;

  localparam int INSTRET_W = 32;
  localparam int EW = 16 + 32 + 15;

  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_RTYPE  = 7'b0110011;
  localparam logic [6:0] OP_ITYPE  = 7'b0010011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;
  localparam logic [6:0] OP_BAD    = 7'b0000000;

  // {mem_read, mem_write, adr_src, ir_write, pc_write, reg_write, a, b, op, rs, ill}
  function automatic logic [14:0] mk(input logic mr, input logic mw, input logic adr,
                                     input logic irw, input logic pcw, input logic rw,
                                     input logic [1:0] a, input logic [1:0] b,
                                     input logic [1:0] op, input logic [1:0] rs,
                                     input logic ill);
    return {mr, mw, adr, irw, pcw, rw, a, b, op, rs, ill};
  endfunction

  localparam logic [14:0] W_FETCH_GO   = mk(1,0,0,1,1,0,2'd0,2'd2,2'd0,2'd2,0);
  localparam logic [14:0] W_FETCH_WAIT = mk(1,0,0,0,0,0,2'd0,2'd2,2'd0,2'd2,0);
  localparam logic [14:0] W_FETCH_RST  = mk(0,0,0,0,0,0,2'd0,2'd2,2'd0,2'd2,0);
  localparam logic [14:0] W_DECODE     = mk(0,0,0,0,0,0,2'd1,2'd1,2'd0,2'd0,0);
  localparam logic [14:0] W_MEMADR     = mk(0,0,0,0,0,0,2'd2,2'd1,2'd0,2'd0,0);
  localparam logic [14:0] W_MEMREAD    = mk(1,0,1,0,0,0,2'd0,2'd0,2'd0,2'd0,0);
  localparam logic [14:0] W_MEMWB      = mk(0,0,0,0,0,1,2'd0,2'd0,2'd0,2'd1,0);
  localparam logic [14:0] W_MEMWRITE   = mk(0,1,1,0,0,0,2'd0,2'd0,2'd0,2'd0,0);
  localparam logic [14:0] W_MEMWR_RST  = mk(0,0,1,0,0,0,2'd0,2'd0,2'd0,2'd0,0);
  localparam logic [14:0] W_EXECR      = mk(0,0,0,0,0,0,2'd2,2'd0,2'd2,2'd0,0);
  localparam logic [14:0] W_EXECI      = mk(0,0,0,0,0,0,2'd2,2'd1,2'd3,2'd0,0);
  localparam logic [14:0] W_LUI        = mk(0,0,0,0,0,0,2'd3,2'd1,2'd0,2'd0,0);
  localparam logic [14:0] W_ALUWB      = mk(0,0,0,0,0,1,2'd0,2'd0,2'd0,2'd0,0);
  localparam logic [14:0] W_BR_T       = mk(0,0,0,0,1,0,2'd2,2'd0,2'd1,2'd0,0);
  localparam logic [14:0] W_BR_N       = mk(0,0,0,0,0,0,2'd2,2'd0,2'd1,2'd0,0);
  localparam logic [14:0] W_JALR       = mk(0,0,0,0,0,0,2'd2,2'd1,2'd0,2'd0,0);
  localparam logic [14:0] W_JAL        = mk(0,0,0,0,1,0,2'd1,2'd2,2'd0,2'd0,0);
  localparam logic [14:0] W_TRAP       = mk(0,0,0,0,0,0,2'd0,2'd0,2'd0,2'd0,1);

  logic                 clk;
  logic                 reset;
  logic [6:0]           opcode;
  logic                 branch_taken;
  logic                 mem_ready;
  logic                 mem_read;
  logic                 mem_write;
  logic                 adr_src;
  logic                 ir_write;
  logic                 pc_write;
  logic                 reg_write;
  logic [1:0]           alu_src_a;
  logic [1:0]           alu_src_b;
  logic [1:0]           alu_op;
  logic [1:0]           result_src;
  logic                 illegal_instr;
  logic [INSTRET_W-1:0] instret;
  logic [3:0]           dbg_state;

  logic [EW-1:0] exp_q[$];
  int checks;
  int failures;
  int step_no;
  logic driving_done;

  multicycle_control #(.INSTRET_W(INSTRET_W)) dut (
    .clk           (clk),
    .reset         (reset),
    .opcode        (opcode),
    .branch_taken  (branch_taken),
    .mem_ready     (mem_ready),
    .mem_read      (mem_read),
    .mem_write     (mem_write),
    .adr_src       (adr_src),
    .ir_write      (ir_write),
    .pc_write      (pc_write),
    .reg_write     (reg_write),
    .alu_src_a     (alu_src_a),
    .alu_src_b     (alu_src_b),
    .alu_op        (alu_op),
    .result_src    (result_src),
    .illegal_instr (illegal_instr),
    .instret       (instret),
    .dbg_state     (dbg_state)
  );

  // Clock and reset
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Driver: one call per clock cycle, inputs applied just after the edge.
  task automatic cyc(input logic rst, input logic [6:0] opc, input logic bt,
                     input logic mr, input logic [14:0] w, input logic [31:0] ir);
    @(posedge clk);
    #1;
    reset        = rst;
    opcode       = opc;
    branch_taken = bt;
    mem_ready    = mr;
    step_no      = step_no + 1;
    exp_q.push_back({step_no[15:0], ir, w});
  endtask

  // Monitor / scoreboard
  always @(negedge clk) begin
    logic [EW-1:0] e;
    logic [14:0]   act_w;
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      act_w = {mem_read, mem_write, adr_src, ir_write, pc_write, reg_write,
               alu_src_a, alu_src_b, alu_op, result_src, illegal_instr};
      checks = checks + 1;
      if (act_w !== e[14:0]) begin
        failures = failures + 1;
        $display("FAIL ctl step=%0d got=%b required=%b", e[EW-1:EW-16], act_w, e[14:0]);
      end
      checks = checks + 1;
      if (instret !== e[46:15]) begin
        failures = failures + 1;
        $display("FAIL instret step=%0d got=%0d required=%0d", e[EW-1:EW-16], instret, e[46:15]);
      end
    end
  end

  int ir;

  initial begin
    checks = 0;
    failures = 0;
    step_no = 0;
    driving_done = 1'b0;
    reset = 1'b1;
    opcode = OP_RTYPE;
    branch_taken = 1'b0;
    mem_ready = 1'b1;
    ir = 0;

    // Reset held for two cycles; the second shows FETCH with enables masked.
    @(posedge clk);
    #1;
    cyc(1, OP_RTYPE, 0, 1, W_FETCH_RST, 0);

    // R-type: 4 cycles
    cyc(0, OP_RTYPE, 0, 1, W_FETCH_GO, ir);
    cyc(0, OP_RTYPE, 0, 1, W_DECODE, ir);
    cyc(0, OP_RTYPE, 0, 1, W_EXECR, ir);
    cyc(0, OP_RTYPE, 0, 1, W_ALUWB, ir);
    ir++;

    // Load with three wait cycles in MEMREAD: 8 cycles
    cyc(0, OP_LOAD, 0, 1, W_FETCH_GO, ir);
    cyc(0, OP_LOAD, 0, 1, W_DECODE, ir);
    cyc(0, OP_LOAD, 0, 1, W_MEMADR, ir);
    for (int i = 0; i < 3; i++) cyc(0, OP_LOAD, 0, 0, W_MEMREAD, ir);
    cyc(0, OP_LOAD, 0, 1, W_MEMREAD, ir);
    cyc(0, OP_LOAD, 0, 1, W_MEMWB, ir);
    ir++;

    // Store: 4 cycles
    cyc(0, OP_STORE, 0, 1, W_FETCH_GO, ir);
    cyc(0, OP_STORE, 0, 1, W_DECODE, ir);
    cyc(0, OP_STORE, 0, 1, W_MEMADR, ir);
    cyc(0, OP_STORE, 0, 1, W_MEMWRITE, ir);
    ir++;

    // I-type: 4 cycles
    cyc(0, OP_ITYPE, 0, 1, W_FETCH_GO, ir);
    cyc(0, OP_ITYPE, 0, 1, W_DECODE, ir);
    cyc(0, OP_ITYPE, 0, 1, W_EXECI, ir);
    cyc(0, OP_ITYPE, 0, 1, W_ALUWB, ir);
    ir++;

    // LUI: 4 cycles
    cyc(0, OP_LUI, 0, 1, W_FETCH_GO, ir);
    cyc(0, OP_LUI, 0, 1, W_DECODE, ir);
    cyc(0, OP_LUI, 0, 1, W_LUI, ir);
    cyc(0, OP_LUI, 0, 1, W_ALUWB, ir);
    ir++;

    // AUIPC: 3 cycles
    cyc(0, OP_AUIPC, 0, 1, W_FETCH_GO, ir);
    cyc(0, OP_AUIPC, 0, 1, W_DECODE, ir);
    cyc(0, OP_AUIPC, 0, 1, W_ALUWB, ir);
    ir++;

    // Branch taken / not taken: 3 cycles each
    cyc(0, OP_BRANCH, 1, 1, W_FETCH_GO, ir);
    cyc(0, OP_BRANCH, 1, 1, W_DECODE, ir);
    cyc(0, OP_BRANCH, 1, 1, W_BR_T, ir);
    ir++;
    cyc(0, OP_BRANCH, 0, 1, W_FETCH_GO, ir);
    cyc(0, OP_BRANCH, 0, 1, W_DECODE, ir);
    cyc(0, OP_BRANCH, 0, 1, W_BR_N, ir);
    ir++;

    // JAL: 4 cycles
    cyc(0, OP_JAL, 0, 1, W_FETCH_GO, ir);
    cyc(0, OP_JAL, 0, 1, W_DECODE, ir);
    cyc(0, OP_JAL, 0, 1, W_JAL, ir);
    cyc(0, OP_JAL, 0, 1, W_ALUWB, ir);
    ir++;

    // JALR: 5 cycles
    cyc(0, OP_JALR, 0, 1, W_FETCH_GO, ir);
    cyc(0, OP_JALR, 0, 1, W_DECODE, ir);
    cyc(0, OP_JALR, 0, 1, W_JALR, ir);
    cyc(0, OP_JALR, 0, 1, W_JAL, ir);
    cyc(0, OP_JALR, 0, 1, W_ALUWB, ir);
    ir++;

    // Fetch wait, then an unknown opcode
    cyc(0, OP_BAD, 0, 0, W_FETCH_WAIT, ir);
    cyc(0, OP_BAD, 0, 0, W_FETCH_WAIT, ir);
    cyc(0, OP_BAD, 0, 1, W_FETCH_GO, ir);
    cyc(0, OP_BAD, 0, 1, W_DECODE, ir);
`ifdef MULTICYCLE_ILLEGAL_TRAP_EN
    for (int i = 0; i < 3; i++) cyc(0, OP_BAD, 0, 1, W_TRAP, ir);
    cyc(1, OP_BAD, 0, 1, W_TRAP, ir);
    ir = 0;
`else
    ir++;
`endif

    // Store interrupted by reset in MEMWRITE: write enable must not fire.
    cyc(0, OP_STORE, 0, 1, W_FETCH_GO, ir);
    cyc(0, OP_STORE, 0, 1, W_DECODE, ir);
    cyc(0, OP_STORE, 0, 1, W_MEMADR, ir);
    cyc(1, OP_STORE, 0, 1, W_MEMWR_RST, ir);
    ir = 0;
    cyc(0, OP_STORE, 0, 0, W_FETCH_WAIT, ir);
    cyc(0, OP_STORE, 0, 1, W_FETCH_GO, ir);

    @(posedge clk);
    @(posedge clk);
    checks = checks + 1;
    if (exp_q.size() != 0) begin
      failures = failures + 1;
      $display("FAIL drain got=%0d required=0", exp_q.size());
    end
    driving_done = 1'b1;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
